// File: rtl/sdram_rd_buf.sv
// Read-return stage beside sdram_c: accepts read commands, issues one rd_req per burst,
// captures returned beats into a show-ahead FIFO and streams them out with a last flag.
module sdram_rd_buf #(
  parameter int DW      = 48,
  parameter int AW      = 23,
  parameter int LW      = 9,
  parameter int FAW     = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          rd_req,
  output logic [AW-1:0] ctl_addr,
  output logic [LW-1:0] ctl_cnt,
  input  logic          rd_vld,
  input  logic [DW-1:0] rd_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic          dout_last,
  output logic [FAW:0]  level,
  output logic          tmo_err,
  output logic          stray_err
);

  localparam int DEPTH = 1 << FAW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t         state, state_nxt;
  logic           released;
  logic [LW-1:0]  beat;
  logic [TW-1:0]  tmo;
  logic [DW:0]    mem [DEPTH];
  logic [FAW-1:0] wr_ptr, rd_ptr;
  logic [31:0]    room;
  logic           full, push, pop, accept, last_beat;

  assign room      = DEPTH - 32'(level);
  assign cmd_ready = (state == IDLE) && released && (room >= 32'(cmd_len));
  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = (beat == ctl_cnt - LW'(1));
  assign full      = (level == (FAW+1)'(DEPTH));
  assign push      = (state == DATA) && rd_vld && !full;
  assign pop       = dout_valid && dout_ready;
  // Beats outside a burst, or that would overflow, are dropped and reported.
  assign stray_err = rd_vld && ((state != DATA) || full);

  assign dout_valid = (level != '0);
  assign dout_data  = dout_valid ? mem[rd_ptr][DW-1:0] : '0;
  assign dout_last  = dout_valid ? mem[rd_ptr][DW]     : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      released <= 1'b0;
    end else begin
      state    <= state_nxt;
      released <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    tmo_err   = 1'b0;
    case (state)
      IDLE: if (accept && (cmd_len != '0)) state_nxt = REQ;
      REQ: begin
        rd_req    = 1'b1;
        state_nxt = DATA;
      end
      DATA: begin
        // A beat arriving on the expiry cycle still wins over the timeout.
        if (rd_vld) begin
          if (last_beat) state_nxt = IDLE;
        end else if (tmo == TW'(TIMEOUT)) begin
          tmo_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_addr <= '0;
      ctl_cnt  <= '0;
    end else if (accept) begin
      ctl_addr <= cmd_addr;
      ctl_cnt  <= cmd_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      tmo  <= '0;
    end else if (state == REQ) begin
      beat <= '0;
      tmo  <= '0;
    end else if (state == DATA) begin
      if (rd_vld) begin
        beat <= beat + LW'(1);
        tmo  <= '0;
      end else begin
        tmo  <= tmo + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last_beat, rd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FAW'(1);
      if (pop)  rd_ptr <= rd_ptr + FAW'(1);
      case ({push, pop})
        2'b10:   level <= level + (FAW+1)'(1);
        2'b01:   level <= level - (FAW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rd_buf.sv
// Directed bench for sdram_rd_buf: inputs change just after posedge, outputs sampled at negedge.
module tb_sdram_rd_buf;
  localparam int DW = 48, AW = 23, LW = 9, FAW = 9;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          rd_req;
  logic [AW-1:0] ctl_addr;
  logic [LW-1:0] ctl_cnt;
  logic          rd_vld = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          dout_valid, dout_ready = 1'b0, dout_last;
  logic [DW-1:0] dout_data;
  logic [FAW:0]  level;
  logic          tmo_err, stray_err;

  int errors = 0, checks = 0;

  sdram_rd_buf #(.DW(DW), .AW(AW), .LW(LW), .FAW(FAW), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_req(rd_req), .ctl_addr(ctl_addr),
    .ctl_cnt(ctl_cnt), .rd_vld(rd_vld), .rd_data(rd_data), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .level(level), .tmo_err(tmo_err), .stray_err(stray_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req got %b exp 0", rd_req); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %b exp 0", dout_valid); end
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if ({tmo_err, stray_err} !== 2'b00) begin errors++; $display("FAIL rst_errs got %b exp 00", {tmo_err, stray_err}); end
    checks++; if ({ctl_addr, ctl_cnt} !== '0) begin errors++; $display("FAIL rst_ctl got %h/%h exp 0/0", ctl_addr, ctl_cnt); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_hold got %b exp 0", cmd_ready); end
    cyc();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_basic();
    cyc();
    dout_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 23'h400501; cmd_len = 9'd5;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b_cmd_ready got %b exp 1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL b_rd_req got %b exp 1", rd_req); end
    checks++; if (ctl_addr !== 23'h400501) begin errors++; $display("FAIL b_ctl_addr got %h exp 400501", ctl_addr); end
    checks++; if (ctl_cnt !== 9'd5) begin errors++; $display("FAIL b_ctl_cnt got %0d exp 5", ctl_cnt); end
    cyc();
    for (int i = 0; i < 5; i++) begin
      rd_vld = 1'b1; rd_data = DW'(10 + i);
      cyc();
      rd_vld = 1'b0;
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1 || dout_data !== DW'(10 + i) || dout_last !== (i == 4))
        begin errors++; $display("FAIL b_dout[%0d] got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", i, dout_valid, dout_data, dout_last, 10 + i, i == 4); end
      checks++; if (rd_req !== 1'b0 || level !== 10'd1 || stray_err !== 1'b0)
        begin errors++; $display("FAIL b_flow[%0d] got req=%b lvl=%0d stray=%b exp 0/1/0", i, rd_req, level, stray_err); end
    end
    cyc();
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0 || level !== 10'd0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL b_end got v=%b lvl=%0d rdy=%b exp 0/0/1", dout_valid, level, cmd_ready); end
    dout_ready = 1'b0;
  endtask

  task automatic test_len0();
    cyc();
    cmd_valid = 1'b1; cmd_addr = 23'h7; cmd_len = 9'd0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL z_ready got %b exp 1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rd_req !== 1'b0 || cmd_ready !== 1'b1 || level !== 10'd0)
        begin errors++; $display("FAIL z_idle[%0d] got req=%b rdy=%b lvl=%0d exp 0/1/0", i, rd_req, cmd_ready, level); end
      cyc();
    end
    checks++; if (ctl_addr !== 23'h7) begin errors++; $display("FAIL z_ctl_addr got %h exp 7", ctl_addr); end
  endtask

  task automatic test_stray();
    rd_vld = 1'b1; rd_data = 48'hdead;
    @(negedge clk);
    checks++; if (stray_err !== 1'b1) begin errors++; $display("FAIL s_pulse got %b exp 1", stray_err); end
    cyc();
    rd_vld = 1'b0;
    @(negedge clk);
    checks++; if (stray_err !== 1'b0 || level !== 10'd0 || dout_valid !== 1'b0)
      begin errors++; $display("FAIL s_after got stray=%b lvl=%0d v=%b exp 0/0/0", stray_err, level, dout_valid); end
    cyc();
  endtask

  task automatic test_backpressure();
    int exp_d;
    dout_ready = 1'b0; cmd_valid = 1'b1; cmd_addr = 23'h100; cmd_len = 9'd300;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    for (int i = 0; i < 300; i++) begin
      rd_vld = 1'b1; rd_data = DW'(1000 + i);
      cyc();
      rd_vld = 1'b0;
    end
    cmd_valid = 1'b1; cmd_addr = 23'h200; cmd_len = 9'd300;
    @(negedge clk);
    checks++; if (level !== 10'd300 || dout_data !== DW'(1000) || cmd_ready !== 1'b0)
      begin errors++; $display("FAIL bp_full1 got lvl=%0d d=%0d rdy=%b exp 300/1000/0", level, dout_data, cmd_ready); end
    for (int k = 0; k < 88; k++) begin
      checks++; if (cmd_ready !== 1'b0 || dout_data !== DW'(1000 + k))
        begin errors++; $display("FAIL bp_pop[%0d] got rdy=%b d=%0d exp 0/%0d", k, cmd_ready, dout_data, 1000 + k); end
      dout_ready = 1'b1;
      cyc();
      dout_ready = 1'b0;
      @(negedge clk);
    end
    checks++; if (level !== 10'd212 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL bp_rise got lvl=%0d rdy=%b exp 212/1", level, cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_req !== 1'b1 || ctl_addr !== 23'h200) begin errors++; $display("FAIL bp_req2 got req=%b a=%h exp 1/200", rd_req, ctl_addr); end
    cyc();
    for (int i = 0; i < 300; i++) begin
      rd_vld = 1'b1; rd_data = DW'(2000 + i);
      cyc();
      rd_vld = 1'b0;
    end
    @(negedge clk);
    checks++; if (level !== 10'd512 || stray_err !== 1'b0) begin errors++; $display("FAIL bp_full2 got lvl=%0d stray=%b exp 512/0", level, stray_err); end
    for (int k = 0; k < 512; k++) begin
      exp_d = (k < 212) ? 1088 + k : 2000 + (k - 212);
      checks++; if (dout_valid !== 1'b1 || dout_data !== DW'(exp_d) || dout_last !== (k == 211 || k == 511))
        begin errors++; $display("FAIL bp_drain[%0d] got v=%b d=%0d l=%b exp 1/%0d/%b", k, dout_valid, dout_data, dout_last, exp_d, k == 211 || k == 511); end
      dout_ready = 1'b1;
      cyc();
      dout_ready = 1'b0;
      @(negedge clk);
    end
    checks++; if (level !== 10'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got lvl=%0d v=%b exp 0/0", level, dout_valid); end
    cyc();
  endtask

  task automatic test_timeout();
    dout_ready = 1'b0; cmd_valid = 1'b1; cmd_addr = 23'h10; cmd_len = 9'd5;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      rd_vld = 1'b1; rd_data = DW'(30 + i);
      cyc();
      rd_vld = 1'b0;
    end
    for (int k = 1; k <= 64; k++) begin
      cyc();
      @(negedge clk);
      checks++; if (tmo_err !== (k == 64)) begin errors++; $display("FAIL t_tmo[%0d] got %b exp %b", k, tmo_err, k == 64); end
    end
    cyc();
    @(negedge clk);
    checks++; if (tmo_err !== 1'b0 || level !== 10'd3 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL t_after got tmo=%b lvl=%0d rdy=%b exp 0/3/1", tmo_err, level, cmd_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (dout_data !== DW'(30 + k) || dout_last !== 1'b0)
        begin errors++; $display("FAIL t_drain[%0d] got d=%0d l=%b exp %0d/0", k, dout_data, dout_last, 30 + k); end
      dout_ready = 1'b1;
      cyc();
      dout_ready = 1'b0;
      @(negedge clk);
    end
    cmd_valid = 1'b1; cmd_addr = 23'h20; cmd_len = 9'd2;
    cyc();
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_req !== 1'b1 || ctl_cnt !== 9'd2) begin errors++; $display("FAIL t_next_req got req=%b cnt=%0d exp 1/2", rd_req, ctl_cnt); end
    cyc();
    for (int i = 0; i < 2; i++) begin
      rd_vld = 1'b1; rd_data = DW'(40 + i);
      cyc();
      rd_vld = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (dout_valid !== 1'b1 || dout_data !== DW'(40 + k) || dout_last !== (k == 1))
        begin errors++; $display("FAIL t_next[%0d] got v=%b d=%0d l=%b exp 1/%0d/%b", k, dout_valid, dout_data, dout_last, 40 + k, k == 1); end
      dout_ready = 1'b1;
      cyc();
      dout_ready = 1'b0;
      @(negedge clk);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0; cmd_valid = 1'b1; cmd_addr = 23'h30; cmd_len = 9'd8;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      rd_vld = 1'b1; rd_data = DW'(50 + i);
      cyc();
      rd_vld = 1'b0;
    end
    @(negedge clk);
    checks++; if (level !== 10'd2) begin errors++; $display("FAIL r_pre got lvl=%0d exp 2", level); end
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 10'd0 || dout_valid !== 1'b0 || {tmo_err, stray_err} !== 2'b00 || cmd_ready !== 1'b0)
      begin errors++; $display("FAIL r_in got lvl=%0d v=%b err=%b rdy=%b exp 0/0/00/0", level, dout_valid, {tmo_err, stray_err}, cmd_ready); end
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd_vld = 1'b1; rd_data = DW'(52 + i);
      @(negedge clk);
      checks++; if (stray_err !== 1'b1) begin errors++; $display("FAIL r_stray[%0d] got %b exp 1", i, stray_err); end
      if (i == 0) begin
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL r_hold got %b exp 0", cmd_ready); end
      end
      cyc();
      rd_vld = 1'b0;
    end
    @(negedge clk);
    checks++; if (level !== 10'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL r_drop got lvl=%0d v=%b exp 0/0", level, dout_valid); end
    cmd_valid = 1'b1; cmd_addr = 23'h40; cmd_len = 9'd1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL r_new_ready got %b exp 1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL r_new_req got %b exp 1", rd_req); end
    cyc();
    rd_vld = 1'b1; rd_data = DW'(77);
    cyc();
    rd_vld = 1'b0;
    @(negedge clk);
    checks++; if (dout_valid !== 1'b1 || dout_data !== DW'(77) || dout_last !== 1'b1)
      begin errors++; $display("FAIL r_new_dout got v=%b d=%0d l=%b exp 1/77/1", dout_valid, dout_data, dout_last); end
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stray();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
